// File: rtl/time_display_scan.sv
// time_display_scan: binary HH:MM:SS to BCD via subtract-10 FSM, scanned onto a 6-digit 7-segment display
// Ports: clk, rst_n (async, active-low); set_mode/set_hour/set_min select the blinking field;
//   hour/minute/second binary inputs; seg {g..a} active-high; dig_sel one-hot digit enable;
//   busy high while a BCD conversion is running.
module time_display_scan #(
  parameter int SCAN_DIV   = 1,
  parameter int BLINK_HALF = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_mode,
  input  logic       set_hour,
  input  logic       set_min,
  input  logic [4:0] hour,
  input  logic [5:0] minute,
  input  logic [5:0] second,
  output logic [6:0] seg,
  output logic [5:0] dig_sel,
  output logic       busy
);
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int BW = BLINK_HALF > 1 ? $clog2(BLINK_HALF) : 1;
  localparam logic [SW-1:0] S_MAX = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] B_MAX = BW'(BLINK_HALF - 1);

  typedef enum logic {IDLE, CONV} state_t;
  state_t state, state_nx;

  logic [16:0]     snap;
  logic [4:0]      wh;
  logic [5:0]      wm, ws;
  logic [3:0]      th, tm, ts;
  logic [5:0][3:0] bcd;
  logic [SW-1:0]   scan_cnt;
  logic [BW-1:0]   blink_cnt;
  logic [2:0]      dig_idx;
  logic            blink_on, changed, done, blank;
  logic [3:0]      cur;
  logic [6:0]      dec;

  assign changed = {hour, minute, second} != snap;
  assign done    = wh < 5'd10 && wm < 6'd10 && ws < 6'd10;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;

  always_comb state_nx = state == IDLE ? (changed ? CONV : IDLE) : (done ? IDLE : CONV);

  always_comb busy = state == CONV;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      snap <= '0;
      wh   <= '0;
      wm   <= '0;
      ws   <= '0;
      th   <= '0;
      tm   <= '0;
      ts   <= '0;
      bcd  <= '0;
    end else if (state == IDLE && changed) begin
      snap <= {hour, minute, second};
      wh   <= hour;
      wm   <= minute;
      ws   <= second;
      th   <= '0;
      tm   <= '0;
      ts   <= '0;
    end else if (state == CONV && done) begin
      bcd <= {th, wh[3:0], tm, wm[3:0], ts, ws[3:0]};
    end else if (state == CONV) begin
      if (wh >= 5'd10) begin
        wh <= wh - 5'd10;
        th <= th + 4'd1;
      end
      if (wm >= 6'd10) begin
        wm <= wm - 6'd10;
        tm <= tm + 4'd1;
      end
      if (ws >= 6'd10) begin
        ws <= ws - 6'd10;
        ts <= ts + 4'd1;
      end
    end

  always_comb cur = dig_idx > 3'd5 ? 4'd0 : bcd[dig_idx];

  always_comb begin
    dec = 7'h00;
    case (cur)
      4'd0: dec = 7'h3F;
      4'd1: dec = 7'h06;
      4'd2: dec = 7'h5B;
      4'd3: dec = 7'h4F;
      4'd4: dec = 7'h66;
      4'd5: dec = 7'h6D;
      4'd6: dec = 7'h7D;
      4'd7: dec = 7'h07;
      4'd8: dec = 7'h7F;
      4'd9: dec = 7'h6F;
      default: dec = 7'h00;
    endcase
  end

  always_comb blank = !blink_on && set_mode &&
                      ((set_hour && dig_idx >= 3'd4) || (set_min && (dig_idx == 3'd2 || dig_idx == 3'd3)));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      scan_cnt  <= '0;
      dig_idx   <= '0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
      seg       <= 7'h00;
      dig_sel   <= 6'b000000;
    end else begin
      scan_cnt  <= scan_cnt == S_MAX ? '0 : scan_cnt + SW'(1);
      blink_cnt <= blink_cnt == B_MAX ? '0 : blink_cnt + BW'(1);
      if (scan_cnt == S_MAX) dig_idx <= dig_idx == 3'd5 ? 3'd0 : dig_idx + 3'd1;
      if (blink_cnt == B_MAX) blink_on <= !blink_on;
      seg     <= blank ? 7'h00 : dec;
      dig_sel <= 6'd1 << dig_idx;
    end
endmodule

// File: tb/tb_time_display_scan.sv
// tb_time_display_scan: randomized and directed checks of time_display_scan against an arithmetic model
module tb_time_display_scan;
  localparam int SD = 3;
  localparam int BH = 4;

  logic       clk = 0, rst_n = 0, set_mode = 0, set_hour = 0, set_min = 0;
  logic [4:0] hour = 0;
  logic [5:0] minute = 0, second = 0;
  logic [6:0] seg;
  logic [5:0] dig_sel;
  logic       busy;

  time_display_scan #(.SCAN_DIV(SD), .BLINK_HALF(BH)) dut (
    .clk(clk), .rst_n(rst_n), .set_mode(set_mode), .set_hour(set_hour), .set_min(set_min),
    .hour(hour), .minute(minute), .second(second), .seg(seg), .dig_sel(dig_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int e, s_h, s_m, s_s, d_h, d_m, d_s, done_e;
  bit conv;
  logic [6:0] x_seg;
  logic [5:0] x_dig;
  logic       x_busy;
  logic [6:0] lut [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    e = 0; s_h = 0; s_m = 0; s_s = 0; d_h = 0; d_m = 0; d_s = 0; done_e = 0; conv = 0;
    x_seg = 0; x_dig = 0; x_busy = 0;
  endtask

  function automatic int dval(int d);
    case (d)
      0: return d_s % 10;
      1: return d_s / 10;
      2: return d_m % 10;
      3: return d_m / 10;
      4: return d_h % 10;
      default: return d_h / 10;
    endcase
  endfunction

  // Expected outputs after the edge now occurring, from edge count and displayed time.
  task automatic model_edge();
    int d, k;
    bit bon, blk;
    d   = (e / SD) % 6;
    bon = ((e / BH) % 2) == 0;
    blk = !bon && set_mode && ((set_hour && d >= 4) || (set_min && (d == 2 || d == 3)));
    x_seg = blk ? 7'h00 : lut[dval(d)];
    x_dig = 6'(1 << d);
    if (!conv) begin
      if (int'(hour) != s_h || int'(minute) != s_m || int'(second) != s_s) begin
        s_h = hour; s_m = minute; s_s = second;
        k = s_h / 10;
        if (s_m / 10 > k) k = s_m / 10;
        if (s_s / 10 > k) k = s_s / 10;
        done_e = e + k + 1;
        conv = 1;
      end
    end else if (e == done_e) begin
      conv = 0;
      d_h = s_h; d_m = s_m; d_s = s_s;
    end
    x_busy = conv;
    e++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("seg", seg, x_seg);
    chk("dig_sel", dig_sel, x_dig);
    chk("busy", busy, x_busy);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hour = 5'(h); minute = 6'(m); second = 6'(s);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_seg", seg, 7'h00);
    chk("rst_dig", dig_sel, 6'b0);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1;
    run(40);
    set_time(12, 34, 56);
    run(45);
    set_time(23, 59, 59);
    run(20);
    set_time(0, 0, 0);
    run(24);
    set_mode = 1; set_hour = 1;
    run(40);
    set_min = 1;
    run(40);
    set_hour = 0;
    run(40);
    set_mode = 0; set_hour = 1;
    run(40);
    set_hour = 0; set_min = 0;
    set_time(12, 59, 59);
    run(2);
    set_time(12, 10, 59);
    run(30);
    set_time(31, 63, 63);
    run(40);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 3) == 0) set_time($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
        else set_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      end
      if (i % 24 == 0) begin
        set_mode = 1'($urandom_range(0, 1));
        set_hour = 1'($urandom_range(0, 1));
        set_min  = 1'($urandom_range(0, 1));
      end
      tick();
    end
    set_mode = 0;
    set_time(23, 59, 58);
    run(2);
    chk("busy_before_reset", busy, 1'b1);
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("async_rst_seg", seg, 7'h00);
    chk("async_rst_dig", dig_sel, 6'b0);
    chk("async_rst_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    chk("held_rst_seg", seg, 7'h00);
    chk("held_rst_busy", busy, 1'b0);
    rst_n = 1;
    run(60);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
